// File: rtl/toy_icache_refill_rd.sv
// Line-refill read sequencer: accepts one line request, streams LINE_WORDS word reads
// from the word-wide memory model, assembles the line and returns it on a valid/ready channel.
module toy_icache_refill_rd #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_vld_i,
  output logic                             req_rdy_o,
  input  logic [ADDR_WIDTH-1:0]            req_addr_i,
  input  logic [ID_WIDTH-1:0]              req_id_i,
  output logic                             resp_vld_o,
  input  logic                             resp_rdy_i,
  output logic [ID_WIDTH-1:0]              resp_id_o,
  output logic [ADDR_WIDTH-1:0]            resp_addr_o,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_data_o,
  output logic                             mem_en_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic                             mem_wr_en_o,
  output logic [DATA_WIDTH-1:0]            mem_wr_data_o,
  input  logic [DATA_WIDTH-1:0]            mem_rd_data_i
);

  // state | meaning
  // IDLE  | waiting for a line request (req_rdy high)
  // ISSUE | one word read per cycle, iss_cnt 0..LINE_WORDS-1
  // DRAIN | last read in flight, final word captured here
  // RESP  | assembled line presented until resp_rdy
  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic [CW-1:0]                    iss_cnt_q, cap_cnt_q;
  logic                             rd_pend_q;
  logic [ADDR_WIDTH-1:0]            base_q;
  logic [ID_WIDTH-1:0]              id_q;
  logic [LINE_WORDS*DATA_WIDTH-1:0] line_q;
  logic                             accept;

  assign req_rdy_o     = (state_q == S_IDLE);
  assign accept        = req_vld_i && req_rdy_o;
  assign resp_vld_o    = (state_q == S_RESP);
  assign resp_id_o     = id_q;
  assign resp_addr_o   = base_q;
  assign resp_data_o   = line_q;
  assign mem_en_o      = (state_q == S_ISSUE);
  // Beat index only fills the zeroed low bits, so it can never carry into the base.
  assign mem_addr_o    = base_q | {{(ADDR_WIDTH-CW){1'b0}}, iss_cnt_q};
  assign mem_wr_en_o   = 1'b0;
  assign mem_wr_data_o = '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_vld_i) state_d = S_ISSUE;
      S_ISSUE: if (iss_cnt_q == LAST) state_d = S_DRAIN;
      S_DRAIN: if (rd_pend_q && (cap_cnt_q == LAST)) state_d = S_RESP;
      S_RESP:  if (resp_rdy_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      iss_cnt_q <= '0;
      cap_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      base_q    <= '0;
      id_q      <= '0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      // Memory returns data one cycle after the read is issued.
      rd_pend_q <= (state_q == S_ISSUE);
      if (accept) begin
        base_q    <= {req_addr_i[ADDR_WIDTH-1:CW], {CW{1'b0}}};
        id_q      <= req_id_i;
        line_q    <= '0;
        iss_cnt_q <= '0;
        cap_cnt_q <= '0;
      end else begin
        if (state_q == S_ISSUE) iss_cnt_q <= iss_cnt_q + 1'b1;
        if (rd_pend_q) begin
          cap_cnt_q <= cap_cnt_q + 1'b1;
          for (int k = 0; k < LINE_WORDS; k++) begin
            if (cap_cnt_q == CW'(k)) line_q[k*DATA_WIDTH +: DATA_WIDTH] <= mem_rd_data_i;
          end
        end
      end
    end
  end

endmodule
